// File: rtl/fcvt_exec_unit.sv
// fcvt_exec_unit: two-stage RV32F FCVT.{W,WU}.S / FCVT.S.{W,WU} unit.
// S1 holds the issued op and decodes it, S2 rounds/saturates and drives the CDB.
module fcvt_exec_unit #(
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [4:0]       out_fflags,
  output logic [TAG_W-1:0] out_tag
);

  logic             s1_valid_q, s1_valid_d;
  logic [1:0]       s1_op_q;
  logic [31:0]      s1_src_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      s2_res_q, s2_res_d;
  logic [4:0]       s2_flg_q, s2_flg_d;
  logic [TAG_W-1:0] s2_tag_q;

  logic s2_load, accept;

  assign s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | s2_load;
  assign accept   = in_valid & in_ready & ~flush;

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (flush) s1_valid_d = 1'b0;
    else if (accept) s1_valid_d = 1'b1;
    else if (s2_load) s1_valid_d = 1'b0;
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    if (flush) s2_valid_d = 1'b0;
    else if (s2_load) s2_valid_d = 1'b1;
    else if (out_ready) s2_valid_d = 1'b0;
  end

  // float decode
  logic              sgn, wu;
  logic [7:0]        exp_b;
  logic [22:0]       frac;
  logic signed [9:0] uexp;
  logic              c_nan, c_ovf, c_zero, c_tiny, c_norm;

  assign sgn   = s1_src_q[31];
  assign exp_b = s1_src_q[30:23];
  assign frac  = s1_src_q[22:0];
  assign wu    = s1_op_q[0];
  assign uexp  = signed'({2'b00, exp_b}) - 10'sd127;

  assign c_nan  = (exp_b == 8'hFF) & (frac != 23'd0);
  assign c_ovf  = (exp_b == 8'hFF) ? (frac == 23'd0) : (uexp > 10'sd31);
  assign c_zero = (exp_b == 8'h00) & (frac == 23'd0);
  assign c_tiny = ~c_zero & (uexp < 10'sd0);
  assign c_norm = (uexp >= 10'sd0) & (uexp <= 10'sd31);

  logic [4:0]  ue5, sh_l, sh_r;
  logic [31:0] mant, mag, sat;
  logic        lost;

  assign ue5  = uexp[4:0];
  assign sh_l = ue5 - 5'd23;
  assign sh_r = 5'd23 - ue5;
  assign mant = {8'd0, 1'b1, frac};
  assign mag  = (ue5 >= 5'd23) ? (mant << sh_l) : (mant >> sh_r);
  assign lost = (ue5 < 5'd23) & (|(mant & ~(32'hFFFF_FFFF << sh_r)));
  assign sat  = wu ? (sgn ? 32'h0 : 32'hFFFF_FFFF)
                   : (sgn ? 32'h8000_0000 : 32'h7FFF_FFFF);

  logic [31:0] f_res;
  logic        f_nv, f_nx;

  always_comb begin
    f_res = 32'd0;
    f_nv  = 1'b0;
    f_nx  = 1'b0;
    unique case (1'b1)
      c_nan: begin
        f_res = wu ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
        f_nv  = 1'b1;
      end
      c_ovf: begin
        f_res = sat;
        f_nv  = 1'b1;
      end
      c_zero: f_res = 32'd0;
      c_tiny: f_nx = 1'b1;
      c_norm: begin
        // |x| >= 1 here, so a negative WU source is always invalid
        if (wu ? sgn
               : (sgn ? (mag > 32'h8000_0000) : mag[31])) begin
          f_res = sat;
          f_nv  = 1'b1;
        end else begin
          f_res = sgn ? -mag : mag;
          f_nx  = lost;
        end
      end
    endcase
  end

  function automatic logic [4:0] lzc32(input logic [31:0] v);
    lzc32 = 5'd0;
    for (int i = 0; i < 32; i++)
      if (v[i]) lzc32 = 5'(31 - i);
  endfunction

  // integer decode and round-to-nearest-even
  logic        ineg, g, st, rup;
  logic [31:0] iabs, norm;
  logic [4:0]  lz;
  logic [24:0] man_r;
  logic [7:0]  exp_r;
  logic [22:0] frac_r;
  logic [31:0] i_res;

  assign ineg   = ~s1_op_q[0] & s1_src_q[31];
  assign iabs   = ineg ? -s1_src_q : s1_src_q;
  assign lz     = lzc32(iabs);
  assign norm   = iabs << lz;
  assign g      = norm[7];
  assign st     = |norm[6:0];
  assign rup    = g & (st | norm[8]);
  assign man_r  = {1'b0, norm[31:8]} + {24'd0, rup};
  assign exp_r  = 8'd158 - {3'd0, lz} + {7'd0, man_r[24]};
  assign frac_r = man_r[24] ? man_r[23:1] : man_r[22:0];
  assign i_res  = (iabs == 32'd0) ? 32'd0 : {ineg, exp_r, frac_r};

  always_comb begin
    s2_res_d = f_res;
    s2_flg_d = {f_nv, 3'b000, f_nx};
    if (s1_op_q[1]) begin
      s2_res_d = i_res;
      s2_flg_d = {4'b0000, g | st};
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_op_q  <= in_op;
      s1_src_q <= in_src;
      s1_tag_q <= in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= 32'd0;
      s2_flg_q   <= 5'd0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s2_load) begin
        s2_res_q <= s2_res_d;
        s2_flg_q <= s2_flg_d;
        s2_tag_q <= s1_tag_q;
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_res_q;
  assign out_fflags = s2_flg_q;
  assign out_tag    = s2_tag_q;

endmodule

// File: tb/tb_fcvt_exec_unit.sv
// tb_fcvt_exec_unit: scoreboard bench for fcvt_exec_unit.
// Expected results come from an arithmetic reference model or a directed table.
module tb_fcvt_exec_unit;
  localparam int TAG_W = 6;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_src;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready;
  logic [31:0]      out_result;
  logic [4:0]       out_fflags;
  logic [TAG_W-1:0] out_tag;

  always #5 clk = ~clk;

  fcvt_exec_unit #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_src(in_src), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_fflags(out_fflags),
    .out_tag(out_tag)
  );

  typedef struct {
    logic [31:0]      res;
    logic [4:0]       flg;
    logic [TAG_W-1:0] tag;
    int               acc;
    bit               exact;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0, errors = 0, cyc = 0, acc_cnt = 0;
  bit   exact_mode = 0, dir_en = 0;
  logic [31:0] dir_res;
  logic [4:0]  dir_flg;

  always @(posedge clk) cyc <= cyc + 1;

  // exact value of the float, truncated, then range-checked
  function automatic void ref_f2i(input bit u, input logic [31:0] x,
                                  output logic [31:0] r, output logic [4:0] fl);
    int     e, sh;
    longint m, mag, v, lo, hi;
    bit     inex, s;
    s  = x[31];
    e  = int'(x[30:23]);
    m  = longint'({1'b1, x[22:0]});
    lo = u ? 64'sd0 : -64'sd2147483648;
    hi = u ? 64'sd4294967295 : 64'sd2147483647;
    if (e == 255 && x[22:0] != 0) begin
      r  = u ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
      fl = 5'h10;
      return;
    end
    if (e == 0) begin
      r  = 32'd0;
      fl = (x[22:0] != 0) ? 5'h01 : 5'h00;
      return;
    end
    sh = e - 150;
    if (e == 255 || sh > 30) begin mag = 64'sd1 << 40; inex = 0; end
    else if (sh >= 0) begin mag = m << sh; inex = 0; end
    else if (sh < -24) begin mag = 0; inex = 1; end
    else begin
      mag  = m >> (-sh);
      inex = ((mag << (-sh)) != m);
    end
    v = s ? -mag : mag;
    if (v < lo || v > hi) begin
      r  = s ? (u ? 32'h0 : 32'h8000_0000) : (u ? 32'hFFFF_FFFF : 32'h7FFF_FFFF);
      fl = 5'h10;
    end else begin
      r  = v[31:0];
      fl = {4'b0000, inex};
    end
  endfunction

  function automatic void ref_i2f(input bit u, input logic [31:0] x,
                                  output logic [31:0] r, output logic [4:0] fl);
    longint v, q, rem, half;
    bit     neg;
    int     p, sh;
    if (u) v = longint'({32'd0, x});
    else v = longint'($signed(x));
    neg = (v < 0);
    if (neg) v = -v;
    if (v == 0) begin r = 32'd0; fl = 5'd0; return; end
    p = 0;
    for (int i = 0; i < 40; i++) if (v[i]) p = i;
    rem = 0;
    if (p <= 23) q = v << (23 - p);
    else begin
      sh   = p - 23;
      q    = v >> sh;
      rem  = v - (q << sh);
      half = 64'sd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'sd1 << 24)) begin q = q >> 1; p = p + 1; end
    end
    r  = {neg, 8'(p + 127), q[22:0]};
    fl = {4'b0000, rem != 0};
  endfunction

  function automatic void model(input logic [1:0] op, input logic [31:0] x,
                                output logic [31:0] r, output logic [4:0] fl);
    if (op[1]) ref_i2f(op[0], x, r, fl);
    else ref_f2i(op[0], x, r, fl);
  endfunction

  // monitor + issue bookkeeping, sampled mid-cycle
  bit               p_stall = 0, p_ctl = 0;
  logic [31:0]      p_res;
  logic [4:0]       p_flg;
  logic [TAG_W-1:0] p_tag;

  always @(negedge clk) begin
    exp_t        e;
    int          lat;
    logic [31:0] r;
    logic [4:0]  fl;
    if (p_stall && !p_ctl) begin
      checks++;
      if (!out_valid || out_result !== p_res || out_fflags !== p_flg || out_tag !== p_tag) begin
        errors++;
        $display("FAIL stall_hold v=%b res=%h/%h flg=%h/%h tag=%h/%h",
                 out_valid, out_result, p_res, out_fflags, p_flg, out_tag, p_tag);
      end
    end
    p_stall = out_valid && !out_ready;
    p_ctl   = rst || flush;
    p_res   = out_result;
    p_flg   = out_fflags;
    p_tag   = out_tag;
    if (rst) sbq.delete();
    else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out res=%h tag=%h required none", out_result, out_tag);
        end else begin
          e   = sbq.pop_front();
          lat = cyc - e.acc;
          if (out_result !== e.res || out_fflags !== e.flg || out_tag !== e.tag ||
              (e.exact ? (lat != 2) : (lat < 2))) begin
            errors++;
            $display("FAIL result res=%h flg=%h tag=%h lat=%0d required res=%h flg=%h tag=%h",
                     out_result, out_fflags, out_tag, lat, e.res, e.flg, e.tag);
          end
        end
      end
      if (in_valid && in_ready && !flush) begin
        if (dir_en) begin r = dir_res; fl = dir_flg; end
        else model(in_op, in_src, r, fl);
        sbq.push_back('{r, fl, in_tag, cyc, exact_mode});
        acc_cnt++;
      end
      if (flush) sbq.delete();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", nm, act, req);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (sbq.size() != 0 || out_valid); i++) tick();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending %0d required 0", sbq.size());
    end
  endtask

  function automatic logic [31:0] gen_src(input logic [1:0] op);
    logic [31:0] x;
    logic [7:0]  e;
    int          k;
    k = $urandom_range(0, 9);
    if (op[1]) begin
      case (k)
        0: x = 32'd0;
        1: x = 32'h8000_0000;
        2: x = 32'h0100_0000 + $urandom_range(0, 7);
        3: x = $urandom_range(0, 300);
        4: x = -$urandom_range(1, 300);
        default: x = $urandom;
      endcase
    end else begin
      case (k)
        0: e = 8'd0;
        1: e = 8'd255;
        2: e = 8'($urandom_range(150, 160));
        default: e = 8'($urandom_range(110, 170));
      endcase
      x = {1'($urandom), e, 23'($urandom)};
      if (k == 9) x[22:0] = 23'd0;
    end
    return x;
  endfunction

  task automatic rand_op();
    in_op  = 2'($urandom);
    in_src = gen_src(in_op);
    in_tag = TAG_W'($urandom);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] src, res;
    logic [4:0]  flg;
  } dvec_t;

  dvec_t dv[$] = '{
    '{2'd0, 32'h40490FDB, 32'h00000003, 5'h01},
    '{2'd0, 32'hC0490FDB, 32'hFFFFFFFD, 5'h01},
    '{2'd0, 32'hCF000000, 32'h80000000, 5'h00},
    '{2'd0, 32'h4F000000, 32'h7FFFFFFF, 5'h10},
    '{2'd1, 32'h4F000000, 32'h80000000, 5'h00},
    '{2'd1, 32'hBF000000, 32'h00000000, 5'h01},
    '{2'd1, 32'hBF800000, 32'h00000000, 5'h10},
    '{2'd0, 32'h7FC00000, 32'h7FFFFFFF, 5'h10},
    '{2'd2, 32'h01000001, 32'h4B800000, 5'h01},
    '{2'd2, 32'h01000003, 32'h4B800002, 5'h01},
    '{2'd2, 32'h80000000, 32'hCF000000, 5'h00},
    '{2'd3, 32'hFFFFFFFF, 32'h4F800000, 5'h01},
    '{2'd0, 32'h00000000, 32'h00000000, 5'h00},
    '{2'd0, 32'h00000001, 32'h00000000, 5'h01},
    '{2'd1, 32'hFF800000, 32'h00000000, 5'h10},
    '{2'd1, 32'h7F800000, 32'hFFFFFFFF, 5'h10},
    '{2'd0, 32'hFFC00000, 32'h7FFFFFFF, 5'h10},
    '{2'd0, 32'hCF000001, 32'h80000000, 5'h10},
    '{2'd2, 32'h00000000, 32'h00000000, 5'h00},
    '{2'd2, 32'hFFFFFFFD, 32'hC0400000, 5'h00}
  };

  initial begin
    int a0;
    rst = 1; flush = 0; in_valid = 0; out_ready = 1;
    in_op = 0; in_src = 0; in_tag = 0;
    dir_res = 0; dir_flg = 0;
    tick(); tick();
    rst = 0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_fflags", {27'd0, out_fflags}, 32'd0);
    chk("rst_out_tag", {26'd0, out_tag}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // directed vectors, back to back with mixed op codes
    exact_mode = 1;
    dir_en = 1;
    foreach (dv[i]) begin
      in_valid = 1; in_op = dv[i].op; in_src = dv[i].src;
      in_tag = TAG_W'(i); dir_res = dv[i].res; dir_flg = dv[i].flg;
      chk("dir_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
    end
    in_valid = 0; dir_en = 0;
    drain();

    // streaming
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; rand_op();
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
    end
    in_valid = 0;
    drain();

    // backpressure
    exact_mode = 0;
    out_ready = 0;
    a0 = acc_cnt;
    repeat (5) begin in_valid = 1; rand_op(); tick(); end
    chk("bp_accepts", 32'(acc_cnt - a0), 32'd2);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 0; out_ready = 1;
    drain();

    // flush with two ops in flight
    out_ready = 0;
    repeat (2) begin in_valid = 1; rand_op(); tick(); end
    flush = 1; in_valid = 1; rand_op();
    tick();
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    flush = 0; in_valid = 0; out_ready = 1;
    tick();
    chk("flush_no_accept", {31'd0, out_valid}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 39) == 0);
      rand_op();
      tick();
    end
    flush = 0; in_valid = 0; out_ready = 1;
    drain();

    // reset mid-stream
    exact_mode = 1;
    repeat (4) begin in_valid = 1; rand_op(); tick(); end
    rst = 1; in_valid = 1; rand_op();
    tick();
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 0; in_valid = 0;
    tick();
    chk("mid_rst_no_accept", {31'd0, out_valid}, 32'd0);
    repeat (6) begin in_valid = 1; rand_op(); tick(); end
    in_valid = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fcvt_exec_unit.md
Name: fcvt_exec_unit

Overview:
- Pipelined FP/integer conversion execution unit in the RV32F datapath.
- Accepts issued FCVT.W.S, FCVT.WU.S, FCVT.S.W and FCVT.S.WU micro-ops from the FP reservation station.
- Produces the RISC-V-compliant result, exception flags and ROB tag for the common data bus arbiter.
- Two-stage valid/ready pipeline with backpressure and flush. Throughput is 1 op/cycle.

Parameters:
- TAG_W, 6, width of the ROB tag carried alongside each op.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  pipeline squash (branch mispredict/exception); drops all in-flight ops
- in_valid  input  1  issue request
- in_ready  output  1  unit can accept an op this cycle
- in_op  input  2  00 FCVT.W.S, 01 FCVT.WU.S, 10 FCVT.S.W, 11 FCVT.S.WU
- in_src  input  32  operand (float bits for op 0x/1x as indicated: float for 00/01, integer for 10/11)
- in_tag  input  TAG_W  ROB tag
- out_valid  output  1  result available
- out_ready  input  1  CDB arbiter grant
- out_result  output  32  integer or single-precision result
- out_fflags  output  5  {NV,DZ,OF,UF,NX}; only NV and NX can be set, DZ/OF/UF always 0
- out_tag  output  TAG_W  ROB tag of result

Behaviour:
- Reset (rst=1 at edge): both stage valid bits clear. out_valid=0, out_result=0, out_fflags=0, out_tag=0. in_ready=1 from the first cycle after reset.
- Stage S1 registers op/src/tag and does decode: class (zero, subnormal, normal, inf, NaN), unbiased exponent, and for int→float the absolute value and sign.
- Stage S2 does the shift/round/saturate and holds the output registers.
- Latency: an op accepted at edge N appears with out_valid=1 after edge N+2.
- Handshake:
  - Accept when in_valid & in_ready.
  - Output retired when out_valid & out_ready.
  - S2 loads when S2 is empty or retiring. S1 advances when S2 loads.
  - in_ready = !s1_valid | s2_loads (combinational, no dependence on in_valid).
  - While stalled (out_valid & !out_ready), out_result/out_fflags/out_tag hold stable.
- Flush: clears s1_valid and s2_valid at the edge; an op offered with flush=1 is not accepted. Flush has priority over accept/advance. Data registers need not clear.
- Float→int: round toward zero; the rounding-mode field is not supported.
  - Zero/subnormal → 0. Subnormal sets NX.
  - |x|<1 nonzero → 0, NX.
  - Otherwise the integer is the truncated magnitude. NX is set if any fraction bits are discarded.
  - W range is [-2^31, 2^31-1]; -2^31 exact is valid with no flags. WU range is [0, 2^32-1].
  - Out of range or ±inf: NV=1, NX=0. W saturates to 0x7FFFFFFF (positive) / 0x80000000 (negative). WU saturates to 0xFFFFFFFF (positive) / 0x00000000 (negative).
  - Negative WU with |x|<1 → 0, NX only, no NV.
  - NaN (any sign): W → 0x7FFFFFFF, WU → 0xFFFFFFFF, NV=1.
- Int→float: round to nearest, ties to even.
  - Source 0 → 0x00000000 (+0).
  - S.W treats the source as signed; S.WU as unsigned.
  - Normalize with a leading-zero count, keep 24 bits, then round using guard and sticky.
  - Mantissa carry-out increments the exponent; no overflow is possible.
  - NX is set when any discarded bit is 1.
- Flags are per-op and not accumulated; fcsr accumulation happens at commit.
- Back-to-back ops with mixed op codes must work without bubbles.

Test Plan:
- W.S with 0x40490FDB (3.14159) → 0x00000003, fflags 0x01. W.S with 0xC0490FDB → 0xFFFFFFFD, fflags 0x01.
- W.S: 0xCF000000 → 0x80000000, flags 0. 0x4F000000 → 0x7FFFFFFF, NV (0x10). WU.S 0x4F000000 → 0x80000000, flags 0. WU.S 0xBF000000 (-0.5) → 0, 0x01. WU.S 0xBF800000 → 0, 0x10. NaN 0x7FC00000 W → 0x7FFFFFFF, 0x10.
- S.W: 16777217 → 0x4B800000, NX. 16777219 → 0x4B800002, NX. 0x80000000 → 0xCF000000, flags 0. S.WU 0xFFFFFFFF → 0x4F800000, NX.
- Streaming: 8 consecutive ops with in_valid held high and out_ready=1 → in_ready stays 1, results appear 2 cycles after each accept, in order, with tags matching.
- Backpressure: out_ready=0 for 5 cycles → at most 2 ops accepted, then in_ready=0, outputs stable. Release → ops drain in order and none is lost or duplicated.
- Flush with 2 ops in flight and in_valid=1 → next cycle out_valid=0, nothing accepted that cycle. rst asserted mid-stream → out_valid=0 and in_ready=1 after the reset edge.
